// File: rtl/mem_arb_ctrl_if.sv
// Cache/RAM bus bundle for the shared-RAM arbiter.
// The slave view belongs to the arbiter. The master view belongs to the
// surrounding caches and the RAM model.
interface mem_arb_ctrl_if #(
  parameter int unsigned WORD_W = 32
);
  // icache side
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              iwait;
  logic [WORD_W-1:0] iload;

  // dcache side
  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              dwait;
  logic [WORD_W-1:0] dload;

  // RAM side
  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  logic [1:0]        ramstate;

  // Sticky error flag
  logic              err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );
endinterface

// File: rtl/mem_arb_ctrl.sv
// Responder for icache/dcache requests against one shared RAM port.
// The dcache has priority. After STARVE_MAX consecutive dcache grants made
// while iREN is pending, the icache is granted next. Each bus access either
// completes, times out, or is aborted by its requester. Every output is
// registered.
module mem_arb_ctrl #(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic          CLK,
  input  logic          RST,
  mem_arb_ctrl_if.slave bus
);

  localparam int unsigned StarveW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int unsigned TmoW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [StarveW-1:0] StarveLimit = StarveW'(STARVE_MAX);
  localparam logic [TmoW-1:0]    TmoLast     = TmoW'(TIMEOUT - 1);

  localparam logic [1:0] RamAccess = 2'd2;
  localparam logic [1:0] RamError  = 2'd3;

  // Marker words returned in place of real data
  localparam logic [WORD_W-1:0] LoadRamErr = WORD_W'(32'hBAD0_BAD0);
  localparam logic [WORD_W-1:0] LoadTmo    = WORD_W'(32'hBAD1_BAD1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StIbus  = 3'd1;
  localparam logic [2:0] StDbus  = 3'd2;
  localparam logic [2:0] StIdone = 3'd3;
  localparam logic [2:0] StDdone = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [StarveW-1:0] starve_cnt_q, starve_cnt_d;
  logic [TmoW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic               iwait_q, iwait_d;
  logic               dwait_q, dwait_d;
  logic [WORD_W-1:0]  iload_q, iload_d;
  logic [WORD_W-1:0]  dload_q, dload_d;
  logic               ram_ren_q, ram_ren_d;
  logic               ram_wen_q, ram_wen_d;
  logic [WORD_W-1:0]  ram_addr_q, ram_addr_d;
  logic [WORD_W-1:0]  ram_store_q, ram_store_d;
  logic               err_q, err_d;

  logic d_pend;
  logic i_forced;
  logic ram_done;
  logic ram_fail;
  logic tmo_hit;

  assign d_pend   = bus.dREN | bus.dWEN;
  assign i_forced = bus.iREN && (starve_cnt_q == StarveLimit);
  assign ram_done = (bus.ramstate == RamAccess);
  assign ram_fail = (bus.ramstate == RamError);
  assign tmo_hit  = (tmo_cnt_q == TmoLast);

  // Next-state and registered-output computation for the arbiter FSM
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    iwait_d      = 1'b1;
    dwait_d      = 1'b1;
    iload_d      = iload_q;
    dload_d      = dload_q;
    ram_ren_d    = ram_ren_q;
    ram_wen_d    = ram_wen_q;
    ram_addr_d   = ram_addr_q;
    ram_store_d  = ram_store_q;
    err_d        = err_q;

    case (state_q)
      StIdle: begin
        ram_ren_d = 1'b0;
        ram_wen_d = 1'b0;
        tmo_cnt_d = '0;
        if (d_pend && !i_forced) begin
          state_d     = StDbus;
          ram_addr_d  = bus.daddr;
          ram_store_d = bus.dstore;
          // A write wins when both dREN and dWEN are set
          ram_wen_d   = bus.dWEN;
          ram_ren_d   = bus.dREN & ~bus.dWEN;
          if (bus.iREN) begin
            if (starve_cnt_q != StarveLimit) begin
              starve_cnt_d = starve_cnt_q + StarveW'(1);
            end
          end else begin
            starve_cnt_d = '0;
          end
        end else if (bus.iREN) begin
          state_d      = StIbus;
          ram_addr_d   = bus.iaddr;
          ram_ren_d    = 1'b1;
          starve_cnt_d = '0;
        end
      end

      StIbus: begin
        if (!bus.iREN) begin
          // Abort beats a same-cycle ACCESS; no wait pulse
          state_d   = StIdle;
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
          tmo_cnt_d = '0;
        end else if (ram_done || ram_fail || tmo_hit) begin
          if (ram_done) begin
            iload_d = bus.ramload;
          end else if (ram_fail) begin
            iload_d = LoadRamErr;
            err_d   = 1'b1;
          end else begin
            iload_d = LoadTmo;
            err_d   = 1'b1;
          end
          state_d   = StIdone;
          iwait_d   = 1'b0;
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
          tmo_cnt_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
      end

      StDbus: begin
        if (!d_pend) begin
          state_d   = StIdle;
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
          tmo_cnt_d = '0;
        end else if (ram_done || ram_fail || tmo_hit) begin
          // Writes never disturb dload, even when they fail
          if (!ram_wen_q) begin
            if (ram_done) begin
              dload_d = bus.ramload;
            end else if (ram_fail) begin
              dload_d = LoadRamErr;
            end else begin
              dload_d = LoadTmo;
            end
          end
          if (!ram_done) begin
            err_d = 1'b1;
          end
          state_d   = StDdone;
          dwait_d   = 1'b0;
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
          tmo_cnt_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
      end

      StIdone, StDdone: begin
        state_d = StIdle;
      end

      default: begin
        state_d   = StIdle;
        ram_ren_d = 1'b0;
        ram_wen_d = 1'b0;
        tmo_cnt_d = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StIdle;
      starve_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      iwait_q      <= 1'b1;
      dwait_q      <= 1'b1;
      iload_q      <= '0;
      dload_q      <= '0;
      ram_ren_q    <= 1'b0;
      ram_wen_q    <= 1'b0;
      ram_addr_q   <= '0;
      ram_store_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      iwait_q      <= iwait_d;
      dwait_q      <= dwait_d;
      iload_q      <= iload_d;
      dload_q      <= dload_d;
      ram_ren_q    <= ram_ren_d;
      ram_wen_q    <= ram_wen_d;
      ram_addr_q   <= ram_addr_d;
      ram_store_q  <= ram_store_d;
      err_q        <= err_d;
    end
  end

  assign bus.iwait    = iwait_q;
  assign bus.dwait    = dwait_q;
  assign bus.iload    = iload_q;
  assign bus.dload    = dload_q;
  assign bus.ramREN   = ram_ren_q;
  assign bus.ramWEN   = ram_wen_q;
  assign bus.ramaddr  = ram_addr_q;
  assign bus.ramstore = ram_store_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Bench for mem_arb_ctrl.
// Directed protocol cases run first, followed by a starvation sequence and
// randomized traffic against a transaction-level memory model. A monitor
// matches every wait pulse against a queue of expected load values.
module tb_mem_arb_ctrl;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned TIMEOUT    = 64;
  localparam logic [31:0] I_BASE     = 32'h0000_1000;
  localparam logic [31:0] D_BASE     = 32'h0000_2000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arb_ctrl_if #(.WORD_W(WORD_W)) bus ();

  mem_arb_ctrl #(
    .WORD_W    (WORD_W),
    .STARVE_MAX(STARVE_MAX),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] ram_mem[logic [31:0]];
  logic [31:0] last_dload_m;
  bit          grants[$];
  bit          rec_on = 1'b0;
  bit          prev_strobe = 1'b0;

  bit          ram_auto = 1'b0;
  int          lat_max = 1;
  int          bus_cnt = 0;
  int          lat = 1;
  logic [1:0]  man_state = 2'd0;
  logic [31:0] man_load = '0;

  function automatic logic [31:0] mem_init(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // RAM device: scripted during directed cases, random latency otherwise
  always begin
    @(posedge clk);
    #2;
    if (!ram_auto) begin
      bus.ramstate = man_state;
      bus.ramload  = man_load;
      bus_cnt      = 0;
    end else if (bus.ramREN || bus.ramWEN) begin
      if (bus_cnt == 0) lat = int'($urandom_range(lat_max, 1));
      bus_cnt++;
      if (bus_cnt == lat) begin
        bus.ramstate = 2'd2;
        if (bus.ramWEN) ram_mem[bus.ramaddr] = bus.ramstore;
        else bus.ramload = ram_mem.exists(bus.ramaddr) ? ram_mem[bus.ramaddr]
                                                       : mem_init(bus.ramaddr);
      end else begin
        bus.ramstate = 2'd1;
      end
    end else begin
      bus_cnt      = 0;
      bus.ramstate = 2'd0;
    end
  end

  // Monitor: scoreboard pops on wait pulses and records grant order
  always @(negedge clk) begin
    if (!bus.iwait) begin
      if (exp_i.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL i_pulse: iwait low with no outstanding icache request");
      end else begin
        chk("iload", bus.iload, exp_i.pop_front());
      end
    end
    if (!bus.dwait) begin
      if (exp_d.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL d_pulse: dwait low with no outstanding dcache request");
      end else begin
        chk("dload", bus.dload, exp_d.pop_front());
      end
    end
    if (bus.ramREN && bus.ramWEN) chk("strobe_exclusive", 32'(bus.ramWEN), 32'd0);
    if (rec_on && (bus.ramREN || bus.ramWEN) && !prev_strobe)
      grants.push_back(bus.ramaddr[13:12] == 2'b01);
    prev_strobe = bus.ramREN || bus.ramWEN;
  end

  task automatic icache_run(int n, int max_gap);
    int gap;
    int k;
    for (int t = 0; t < n; t++) begin
      gap = int'($urandom_range(max_gap, 0));
      repeat (gap) begin
        bus.iREN = 1'b0;
        cyc();
      end
      bus.iaddr = I_BASE + (32'($urandom_range(63, 0)) << 2);
      bus.iREN  = 1'b1;
      exp_i.push_back(mem_init(bus.iaddr));
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (bus.iwait && k < 300);
      if (bus.iwait) begin
        n_checks++;
        n_errors++;
        $display("FAIL i_done_timeout: iwait still %0d after %0d cycles", bus.iwait, k);
      end
      cyc();
    end
    bus.iREN = 1'b0;
  endtask

  task automatic dcache_run(int n, int max_gap);
    int gap;
    int k;
    logic [31:0] addr;
    logic [31:0] v;
    for (int t = 0; t < n; t++) begin
      gap = int'($urandom_range(max_gap, 0));
      repeat (gap) begin
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
        cyc();
      end
      addr      = D_BASE + (32'($urandom_range(15, 0)) << 2);
      bus.daddr = addr;
      if ($urandom_range(1, 0) == 1) begin
        bus.dWEN   = 1'b1;
        bus.dREN   = 1'($urandom_range(1, 0));
        bus.dstore = $urandom();
        ref_mem[addr] = bus.dstore;
        exp_d.push_back(last_dload_m);
      end else begin
        bus.dWEN = 1'b0;
        bus.dREN = 1'b1;
        v = ref_mem.exists(addr) ? ref_mem[addr] : mem_init(addr);
        last_dload_m = v;
        exp_d.push_back(v);
      end
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (bus.dwait && k < 300);
      if (bus.dwait) begin
        n_checks++;
        n_errors++;
        $display("FAIL d_done_timeout: dwait still %0d after %0d cycles", bus.dwait, k);
      end
      cyc();
    end
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int d_run;
    bit exp_g;
    rst = 1'b1;
    bus.iREN = 1'b0; bus.iaddr = '0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
    bus.ramstate = 2'd0; bus.ramload = '0;
    last_dload_m = '0;
    repeat (3) cyc();
    chk("rst_iwait", 32'(bus.iwait), 32'd1);
    chk("rst_dwait", 32'(bus.dwait), 32'd1);
    chk("rst_ramREN", 32'(bus.ramREN), 32'd0);
    chk("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_iload", bus.iload, 32'd0);
    chk("rst_dload", bus.dload, 32'd0);
    chk("rst_ramaddr", bus.ramaddr, 32'd0);
    rst = 1'b0;
    cyc();

    // icache read, ACCESS on the second bus cycle
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    exp_i.push_back(32'h8C22_0004);
    cyc();
    chk("t1_ramREN", 32'(bus.ramREN), 32'd1);
    chk("t1_ramaddr", bus.ramaddr, 32'h40);
    chk("t1_iwait_busy", 32'(bus.iwait), 32'd1);
    man_state = 2'd1;
    cyc();
    man_state = 2'd2; man_load = 32'h8C22_0004;
    cyc();
    chk("t1_iwait_low", 32'(bus.iwait), 32'd0);
    chk("t1_ramREN_drop", 32'(bus.ramREN), 32'd0);
    bus.iREN = 1'b0; man_state = 2'd0;
    cyc();
    chk("t1_iwait_high", 32'(bus.iwait), 32'd1);
    chk("t1_iload_held", bus.iload, 32'h8C22_0004);

    // dREN+dWEN together: write wins
    bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'hDEAD_BEEF;
    exp_d.push_back(last_dload_m);
    cyc();
    chk("t2_ramWEN", 32'(bus.ramWEN), 32'd1);
    chk("t2_ramREN", 32'(bus.ramREN), 32'd0);
    chk("t2_ramstore", bus.ramstore, 32'hDEAD_BEEF);
    chk("t2_ramaddr", bus.ramaddr, 32'h80);
    man_state = 2'd2;
    cyc();
    chk("t2_dwait_low", 32'(bus.dwait), 32'd0);
    bus.dREN = 1'b0; bus.dWEN = 1'b0; man_state = 2'd0;
    cyc();
    chk("t2_dload_kept", bus.dload, last_dload_m);
    chk("t2_err_clear", 32'(bus.err), 32'd0);

    // RAM stuck BUSY: forced completion after TIMEOUT bus cycles
    bus.iREN = 1'b1; bus.iaddr = 32'h44; man_state = 2'd1;
    exp_i.push_back(32'hBAD1_BAD1);
    cyc();
    k = 0;
    while (bus.iwait && k < 200) begin
      if (bus.ramREN) k++;
      cyc();
    end
    chk("t4_bus_cycles", 32'(k), 32'(TIMEOUT));
    chk("t4_err_set", 32'(bus.err), 32'd1);
    bus.iREN = 1'b0; man_state = 2'd0;
    repeat (3) cyc();
    chk("t4_err_sticky", 32'(bus.err), 32'd1);

    // dREN dropped in the same cycle as ACCESS: abort, no pulse
    bus.dREN = 1'b1; bus.daddr = 32'h88;
    cyc();
    man_state = 2'd1;
    cyc();
    man_state = 2'd2; man_load = 32'h1234_5678; bus.dREN = 1'b0;
    cyc();
    chk("t5_ramREN_drop", 32'(bus.ramREN), 32'd0);
    chk("t5_no_pulse", 32'(bus.dwait), 32'd1);
    man_state = 2'd0;
    cyc();
    chk("t5_dwait_idle", 32'(bus.dwait), 32'd1);
    chk("t5_dload_kept", bus.dload, last_dload_m);

    // RAM ERROR on a dcache read
    bus.dREN = 1'b1; bus.daddr = 32'h8C;
    exp_d.push_back(32'hBAD0_BAD0);
    last_dload_m = 32'hBAD0_BAD0;
    cyc();
    man_state = 2'd3;
    cyc();
    chk("terr_dwait_low", 32'(bus.dwait), 32'd0);
    bus.dREN = 1'b0; man_state = 2'd0;
    cyc();
    chk("terr_dload", bus.dload, 32'hBAD0_BAD0);

    // Reset in the middle of a dcache access
    bus.dREN = 1'b1; bus.daddr = 32'h90;
    cyc();
    man_state = 2'd1;
    chk("t6_ramREN_busy", 32'(bus.ramREN), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0; bus.dREN = 1'b0; man_state = 2'd0;
    chk("t6_ramREN", 32'(bus.ramREN), 32'd0);
    chk("t6_ramWEN", 32'(bus.ramWEN), 32'd0);
    chk("t6_dwait", 32'(bus.dwait), 32'd1);
    chk("t6_iwait", 32'(bus.iwait), 32'd1);
    chk("t6_err", 32'(bus.err), 32'd0);
    chk("t6_iload", bus.iload, 32'd0);
    chk("t6_dload", bus.dload, 32'd0);
    last_dload_m = '0;
    cyc();

    // Both caches back-to-back: grant order follows the starvation rule
    ram_auto = 1'b1; lat_max = 1; rec_on = 1'b1;
    fork
      icache_run(2, 0);
      dcache_run(8, 0);
    join
    rec_on = 1'b0;
    chk("starve_grant_count", 32'(grants.size()), 32'd10);
    d_run = 0;
    for (int g = 0; g < 10 && g < grants.size(); g++) begin
      exp_g = (d_run == int'(STARVE_MAX));
      if (exp_g) d_run = 0;
      else d_run++;
      chk($sformatf("starve_grant_%0d_is_icache", g), 32'(grants[g]), 32'(exp_g));
    end

    // Randomized mixed traffic
    lat_max = 4;
    fork
      icache_run(30, 3);
      dcache_run(40, 3);
    join
    repeat (5) cyc();
    chk("exp_i_drained", 32'(exp_i.size()), 32'd0);
    chk("exp_d_drained", 32'(exp_d.size()), 32'd0);
    chk("final_err_clear", 32'(bus.err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
